// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the primitive FIFO: absorbs the one-cycle read latency
// with a 2-entry buffer and presents the words as a valid/ready stream.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rdclock,
    input  logic                 reset,
    output logic                 fifo_rd,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy
);

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [WIDTH-1:0]     slot0_q, slot0_d;
    logic [WIDTH-1:0]     slot1_q, slot1_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic       pop;
    logic       capture;
    logic [1:0] occ_after_pop;
    logic [2:0] pending;

    always_comb begin
        m_valid       = (occ_q != 2'd0) & ~flush;
        pop           = m_valid & m_ready;
        capture       = inflight_q & ~flush;
        occ_after_pop = occ_q - {1'b0, pop};
        // Buffered plus in-flight words after this cycle's pop must leave room
        // for one more, otherwise the next capture would overflow the buffer.
        pending       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd       = ~fifo_empty & ~flush & ~reset & (pending < 3'd2);

        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (capture) begin
            if (occ_after_pop == 2'd0) begin
                slot0_d = fifo_dout;
            end else begin
                slot1_d = fifo_dout;
            end
        end

        if (flush) begin
            occ_d = 2'd0;
        end else begin
            occ_d = occ_after_pop + {1'b0, capture};
        end

        inflight_d = fifo_rd;
        count_d    = count_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge rdclock or posedge reset) begin
        if (reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            count_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            count_q    <= count_d;
        end
    end

    assign m_data     = slot0_q;
    assign word_count = count_q;
    assign busy       = (occ_q != 2'd0) | inflight_q;

    a_no_overflow : assert property (@(posedge rdclock) disable iff (reset)
        !(capture && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model plus a scoreboard of words read but
// not yet delivered, checked every cycle, and directed literal expectations.
module tb_fifo_stream_reader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             rdclock = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] word_count;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               exp_cnt = 0;
    bit               last_rd = 1'b0;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
        .rdclock    (rdclock),
        .reset      (reset),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .flush      (flush),
        .word_count (word_count),
        .busy       (busy)
    );

    always #5 rdclock = ~rdclock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO model and scoreboard: exp_q holds every word read from the FIFO
    // that has been neither delivered nor discarded.
    always @(posedge rdclock or posedge reset) begin : model
        logic [WIDTH-1:0] w;
        if (reset) begin
            exp_q.delete();
            last_rd = 1'b0;
            exp_cnt = 0;
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got_q.push_back(m_data);
                exp_cnt++;
            end
            if (flush) exp_q.delete();
            last_rd = fifo_rd;
            if (fifo_rd && fq.size() != 0) begin
                w = fq.pop_front();
                fifo_dout <= w;
                exp_q.push_back(w);
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    // A word read at the most recent edge is still in flight and not visible.
    always @(negedge rdclock) begin : compare
        int vis;
        #2;
        vis = exp_q.size() - int'(last_rd);
        chk("m_valid", m_valid, int'(!reset && !flush && vis > 0));
        if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
        chk("busy", busy, int'(exp_q.size() != 0));
        chk("word_count", word_count, exp_cnt % (1 << CNT_W));
        chk("rd_while_empty", int'(fifo_rd && fifo_empty), 0);
        chk("occupancy_le_2", int'(exp_q.size() <= 2), 1);
    end

    task automatic tick();
        @(negedge rdclock);
    endtask

    task automatic start_test();
        reset   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        tick();
        fq.delete();
        got_q.delete();
    endtask

    task automatic release_reset();
        tick();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        tick();
        #3;
        chk("drain_within_budget", int'(n < max_cycles), 1);
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        int k;
        int rd_cnt;
        int rdseen;
        int n;
        logic [WIDTH-1:0] src[$];

        // Burst with ready high
        start_test();
        for (int i = 1; i <= 8; i++) fq.push_back(WIDTH'(i));
        m_ready = 1'b1;
        release_reset();
        #3;
        chk("burst_rd_cycle0", fifo_rd, 1);
        chk("burst_valid_cycle0", m_valid, 0);
        k = 0;
        do begin
            tick();
            #3;
            k++;
        end while (!m_valid && k < 10);
        chk("burst_first_beat_latency", k, 2);
        for (int i = 0; i < 8; i++) begin
            chk("burst_beat_valid", m_valid, 1);
            chk("burst_beat_data", m_data, i + 1);
            tick();
            #3;
        end
        chk("burst_word_count", word_count, 8);
        chk("burst_valid_after", m_valid, 0);

        // Backpressure
        start_test();
        for (int i = 0; i < 5; i++) fq.push_back(8'h11 + WIDTH'(i));
        release_reset();
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (fifo_rd) rd_cnt++;
            tick();
        end
        #3;
        chk("bp_rd_pulses", rd_cnt, 2);
        chk("bp_valid_held", m_valid, 1);
        chk("bp_data_held", m_data, 8'h11);
        m_ready = 1'b1;
        drain(30);
        chk("bp_delivered", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("bp_order", got_q[i], 8'h11 + i);
        chk("bp_word_count", word_count, 5);

        // Random ready
        start_test();
        src.delete();
        for (int i = 0; i < 200; i++) src.push_back(WIDTH'($urandom_range(0, 255)));
        foreach (src[i]) fq.push_back(src[i]);
        release_reset();
        n = 0;
        while (got_q.size() < 200 && n < 3000) begin
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        m_ready = 1'b0;
        tick();
        #3;
        chk("rand_within_budget", int'(n < 3000), 1);
        chk("rand_delivered", got_q.size(), 200);
        for (int i = 0; i < 200 && i < got_q.size(); i++) chk("rand_order", got_q[i], src[i]);
        chk("rand_word_count", word_count, 200 % 16);

        // Flush with a word buffered and one in flight
        start_test();
        for (int i = 0; i < 4; i++) fq.push_back(8'h21 + WIDTH'(i));
        m_ready = 1'b1;
        release_reset();
        rdseen = 0;
        n = 0;
        while (n < 10) begin
            #3;
            if (fifo_rd) rdseen++;
            if (rdseen == 2) break;
            tick();
            n++;
        end
        chk("flush_second_rd_seen", rdseen, 2);
        tick();
        flush = 1'b1;
        #3;
        chk("flush_valid_forced_low", m_valid, 0);
        chk("flush_rd_suppressed", fifo_rd, 0);
        chk("flush_busy_before_edge", busy, 1);
        tick();
        flush = 1'b0;
        #3;
        chk("flush_busy_after_edge", busy, 0);
        drain(30);
        chk("flush_delivered", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("flush_next_word", got_q[0], 8'h23);
            chk("flush_last_word", got_q[1], 8'h24);
        end
        chk("flush_word_count", word_count, 2);

        // Async reset mid-burst
        start_test();
        for (int i = 0; i < 10; i++) fq.push_back(8'h31 + WIDTH'(i));
        m_ready = 1'b1;
        release_reset();
        repeat (4) tick();
        #1;
        chk("areset_count_before", word_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", m_valid, 0);
        chk("areset_rd", fifo_rd, 0);
        chk("areset_busy", busy, 0);
        chk("areset_word_count", word_count, 0);
        tick();
        got_q.delete();
        reset = 1'b0;
        drain(30);
        chk("areset_delivered", got_q.size(), 6);
        if (got_q.size() != 0) chk("areset_first_after", got_q[0], 8'h35);
        chk("areset_word_count_after", word_count, 6);

        // Counter wrap
        start_test();
        for (int i = 0; i < 17; i++) fq.push_back(8'h40 + WIDTH'(i));
        m_ready = 1'b1;
        release_reset();
        drain(40);
        chk("wrap_delivered", got_q.size(), 17);
        chk("wrap_word_count", word_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's primitive-based `fifo` block.
- Drains words from the FIFO's `rd`/`dout`/`empty` port and presents them as a valid/ready stream for downstream command parsers, e.g. the motor-command decoder.
- Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one word per clock with `m_ready` held high.
- Provides flush and a delivered-word counter.

Parameters:
- WIDTH, 8, data width; must equal the WIDTH of the attached `fifo`.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- `rdclock`  input  1  single clock; same clock as the FIFO read clock.
- `reset`  input  1  asynchronous, active-high reset.
- `fifo_rd`  output  1  read strobe to FIFO `rd`.
- `fifo_dout`  input  WIDTH  FIFO read data; valid the cycle after `fifo_rd`.
- `fifo_empty`  input  1  FIFO empty flag.
- `m_data`  output  WIDTH  stream data (buffer head).
- `m_valid`  output  1  `m_data` holds a word.
- `m_ready`  input  1  downstream accepts the word.
- `flush`  input  1  discard buffered and in-flight words; suppress reads while high.
- `word_count`  output  CNT_WIDTH  number of words delivered since reset; wraps.
- `busy`  output  1  buffer non-empty or read in flight.

Behaviour:
- Reset (async, active-high) clears all state; takes effect immediately, mid-operation included:
  - `fifo_rd`=0, `m_valid`=0, `m_data`=0, `word_count`=0, `busy`=0.
  - Buffer occupancy `occ`=0; in-flight flag `inflight`=0.
- FIFO contract:
  - `fifo_rd` sampled high at edge N makes `fifo_dout` valid for cycle N+1 only.
  - `fifo_empty` is correct in the cycle after each read/write edge.
- State:
  - `occ` in {0,1,2}.
  - `inflight`=1 in the cycle after `fifo_rd` is issued.
  - Buffer is a 2-entry FIFO: head in slot0, tail in slot1.
- Definitions: `pop` = `m_valid` & `m_ready` & ~`flush`.
- Read issue, combinational: `fifo_rd` = ~`fifo_empty` & ~`flush` & ~`reset` & (`occ` + `inflight` − `pop` < 2).
  - `fifo_rd` is never asserted while `fifo_empty`=1.
- Capture: when `inflight`=1 and `flush`=0, `fifo_dout` is written at the edge.
  - Into slot0 if the buffer is empty after this cycle's pop, else into slot1.
- Simultaneous pop and capture with `occ`=1: slot0 ← `fifo_dout`; `occ` stays 1.
- Simultaneous pop and capture with `occ`=2: slot0 ← slot1, slot1 ← `fifo_dout`; `occ` stays 2.
- Pop without capture: slot0 ← slot1; `occ` decrements.
- Buffer overflow cannot occur by the issue rule. Any capture with `occ`=2 and no pop is a design error and is covered by an assertion.
- Outputs:
  - `m_valid` = (`occ` != 0); `m_data` = slot0, held stable while `m_valid` & ~`m_ready`.
  - `m_data` is don't-care when `m_valid`=0, but is registered (no combinational path from `fifo_dout`).
- Latency: `fifo_empty` falls in cycle 0 (buffer empty, `m_ready`=1) → `fifo_rd`=1 in cycle 0 → `m_valid`=1 in cycle 2.
- Throughput: with `m_ready` tied high, one word per cycle sustained.
- `word_count` increments by 1 on each `pop`; wraps from 2^CNT_WIDTH−1 to 0.
- Flush:
  - While `flush`=1: `fifo_rd`=0; `m_valid` is forced 0 combinationally; no pop is counted.
  - At each edge with `flush`=1: `occ` ← 0, and any in-flight word is discarded (`inflight` ← 0 and not captured).
  - Normal operation resumes the cycle after `flush` falls.
  - Words still in the FIFO are not drained by flush.
- `busy` = (`occ` != 0) | `inflight`.

Test Plan:
- Burst, ready high: FIFO preloaded with 0x01..0x08, `m_ready`=1 → `m_data` 0x01..0x08 on 8 consecutive cycles, first beat 2 cycles after release from reset; `word_count`=8; `fifo_rd` never high while `fifo_empty`=1.
- Backpressure: 5 words loaded, `m_ready`=0 for 10 cycles → exactly 2 `fifo_rd` pulses; `m_data`=first word held stable. Then `m_ready`=1 → remaining order intact (words 1..5), `word_count`=5.
- Random ready: 200 random words, `m_ready` random 50% → output sequence equals input sequence, no drops or duplicates, `word_count`=200, occupancy never exceeds 2.
- Flush with in-flight read: 4 words loaded, assert `flush` for 1 cycle in the cycle after the second `fifo_rd` → both buffered/in-flight words discarded, `m_valid`=0 during flush; the next word delivered is word 3; `word_count` excludes the discarded words.
- Async reset mid-burst: assert `reset` between edges during streaming → `m_valid`, `fifo_rd`, `busy` go 0 immediately without waiting for an edge; `word_count`=0; after release, first output is the next FIFO word.
- Counter wrap: CNT_WIDTH=4, 17 words streamed → `word_count` reads 1.
